// File: rtl/crc_stream_n.sv
`timescale 1ns/1ps
// crc_stream_n: streaming MSB-first CRC engine, IN_BW bits per valid/ready beat.
// Optional macro CRC_CHECK_EN adds check_mode/crc_ok for receive-side FCS checking.
module crc_stream_n #(
    parameter int                CRC_BW  = 8,
    parameter logic [CRC_BW-1:0] POLY    = CRC_BW'('h07),
    parameter int                IN_BW   = 8,
    parameter logic [CRC_BW-1:0] INIT    = '0,
    parameter logic [CRC_BW-1:0] XOR_OUT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_BW-1:0]  in_data,
    input  logic              in_first,
    input  logic              in_last,
    output logic              crc_valid,
    input  logic              crc_ready,
    output logic [CRC_BW-1:0] crc_out,
    output logic              frame_abort
`ifdef CRC_CHECK_EN
    ,
    input  logic              check_mode,
    output logic              crc_ok
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t            state, state_nxt;
    logic [CRC_BW-1:0] rem, seed, rem_nxt;
    logic              accept, restart, release_res;

    // Non-augmented remainder update, one unrolled step per data bit, MSB first.
    function automatic logic [CRC_BW-1:0] fold(input logic [CRC_BW-1:0] r,
                                               input logic [IN_BW-1:0]  d);
        logic [CRC_BW-1:0] acc;
        logic              fb;
        acc = r;
        for (int i = IN_BW - 1; i >= 0; i--) begin
            fb  = acc[CRC_BW-1] ^ d[i];
            acc = {acc[CRC_BW-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return acc;
    endfunction

    assign accept      = in_valid && in_ready;
    assign release_res = (state == HOLD) && crc_ready;
    // A beat in IDLE always opens a frame; in RUN only in_first reopens it.
    assign restart     = (state == IDLE) || in_first;
    assign seed        = restart ? INIT : rem;
    assign rem_nxt     = fold(seed, in_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN: if (accept) state_nxt = in_last ? HOLD : RUN;
            HOLD:      if (crc_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != HOLD);
        crc_valid = (state == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= INIT;
            crc_out     <= '0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= accept && (state == RUN) && in_first;
            if (accept) begin
                rem <= rem_nxt;
                if (in_last) crc_out <= rem_nxt ^ XOR_OUT;
            end else if (release_res) begin
                rem     <= INIT;
                crc_out <= '0;
            end
        end
    end

`ifdef CRC_CHECK_EN
    logic mode_q;

    // check_mode is latched with whichever beat opens the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            crc_ok <= 1'b0;
        end else begin
            if (accept && restart) mode_q <= check_mode;
            if (accept && in_last) begin
                crc_ok <= (restart ? check_mode : mode_q) && (rem_nxt == '0);
            end else if (release_res) begin
                crc_ok <= 1'b0;
            end
        end
    end
`endif

endmodule
